// File: rtl/apb2_initiator_if.sv
// APB2 bus bundle between the initiator and a responder.
// The master modport is the initiator side and the slave modport is the responder side.
interface apb2_initiator_if #(
  parameter int addr_width = 8,
  parameter int data_width = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [addr_width-1:0]   paddr;
  logic [data_width-1:0]   pwdata;
  logic [data_width/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic [data_width-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb2_initiator.sv
// Single-outstanding APB2 initiator: command port -> SETUP/ACCESS -> response port.
// Optional ACCESS wait-state abort is enabled by defining APB2_INITIATOR_TIMEOUT_EN.
module apb2_initiator #(
  parameter int data_width     = 32,
  parameter int addr_width     = 8,
  parameter int timeout_cycles = 16
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [addr_width-1:0]   cmd_addr,
  input  logic [data_width-1:0]   cmd_wdata,
  input  logic [data_width/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [data_width-1:0]   rsp_rdata,
  output logic                    rsp_err,
  apb2_initiator_if.master        apb
);

  if (timeout_cycles < 1 || (data_width % 8) != 0) begin : g_param_check
    $error("apb2_initiator: timeout_cycles must be >= 1 and data_width a multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q,     state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic [data_width-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    pwrite_q,    pwrite_d;
  logic [addr_width-1:0]   paddr_q,     paddr_d;
  logic [data_width-1:0]   pwdata_q,    pwdata_d;
  logic [data_width/8-1:0] pstrb_q,     pstrb_d;

`ifdef APB2_INITIATOR_TIMEOUT_EN
  localparam int cnt_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);
  logic [cnt_w-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
`ifdef APB2_INITIATOR_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          // Reads never drive stale write data or strobes onto the bus.
          pwdata_d    = cmd_write ? cmd_wdata : {data_width{1'b0}};
          pstrb_d     = cmd_write ? cmd_strb  : {(data_width/8){1'b0}};
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end else begin
          state_d     = IDLE;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB2_INITIATOR_TIMEOUT_EN
        wait_cnt_d = {cnt_w{1'b0}};
`endif
      end
      ACCESS: begin
        if (apb.pready) begin
          rsp_rdata_d = pwrite_q ? {data_width{1'b0}} : apb.prdata;
          rsp_err_d   = apb.pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef APB2_INITIATOR_TIMEOUT_EN
        end else if (wait_cnt_q == cnt_last) begin
          rsp_rdata_d = {data_width{1'b0}};
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d  = wait_cnt_q + {{(cnt_w-1){1'b0}}, 1'b1};
          state_d     = ACCESS;
        end
`else
        end else begin
          state_d     = ACCESS;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {data_width{1'b0}};
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {addr_width{1'b0}};
      pwdata_q    <= {data_width{1'b0}};
      pstrb_q     <= {(data_width/8){1'b0}};
`ifdef APB2_INITIATOR_TIMEOUT_EN
      wait_cnt_q  <= {cnt_w{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
`ifdef APB2_INITIATOR_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;
  assign apb.pprot   = 3'b000;

endmodule

// File: tb/tb_apb2_initiator.sv
// Directed self-checking bench for apb2_initiator; covers the timeout build when
// APB2_INITIATOR_TIMEOUT_EN is defined and the unbounded-wait build otherwise.
module tb_apb2_initiator;
  logic        pclk;
  logic        preset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks;
  int n_errors;

  apb2_initiator_if #(.addr_width(8), .data_width(32)) apb ();

  apb2_initiator #(.data_width(32), .addr_width(8), .timeout_cycles(16)) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle 1 ns so registered outputs are stable.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " psel"},      {31'd0, apb.psel},  32'd0);
    check({tag, " penable"},   {31'd0, apb.penable}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    preset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 32'h0; cmd_strb = 4'h0; rsp_ready = 1'b0;
    apb.prdata = 32'h0; apb.pready = 1'b0; apb.pslverr = 1'b0;

    // Reset state
    #12;
    check_idle_outputs("rst");
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst paddr",     {24'd0, apb.paddr}, 32'h0);
    check("rst pwrite",    {31'd0, apb.pwrite}, 32'd0);
    check("rst pwdata",    apb.pwdata, 32'h0);
    check("rst pstrb",     {28'd0, apb.pstrb}, 32'h0);
    check("rst pprot",     {29'd0, apb.pprot}, 32'h0);
    preset_n = 1'b1;
    step();

    // Zero-wait read at 0x04; stray wdata/strb must not reach the bus
    send_cmd(1'b0, 8'h04, 32'hFFFF_FFFF, 4'hF);
    apb.pready = 1'b1; apb.prdata = 32'h0000_1234;
    step(); // E0
    cmd_valid = 1'b0;
    check("rd setup psel",    {31'd0, apb.psel}, 32'd1);
    check("rd setup penable", {31'd0, apb.penable}, 32'd0);
    check("rd setup cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rd paddr",  {24'd0, apb.paddr}, 32'h04);
    check("rd pwdata", apb.pwdata, 32'h0);
    check("rd pstrb",  {28'd0, apb.pstrb}, 32'h0);
    check("rd pwrite", {31'd0, apb.pwrite}, 32'd0);
    step(); // E1
    check("rd access psel",    {31'd0, apb.psel}, 32'd1);
    check("rd access penable", {31'd0, apb.penable}, 32'd1);
    check("rd access rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step(); // E2
    check("rd rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd rsp_rdata", rsp_rdata, 32'h0000_1234);
    check("rd rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rd done psel", {31'd0, apb.psel}, 32'd0);
    rsp_ready = 1'b1;
    step(); // E3
    check_idle_outputs("rd retire");
    rsp_ready = 1'b0;

    // Write with 3 wait states
    send_cmd(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF);
    apb.pready = 1'b0; apb.prdata = 32'hAAAA_5555;
    step(); // E0
    cmd_valid = 1'b0;
    check("wr pwrite", {31'd0, apb.pwrite}, 32'd1);
    check("wr pwdata", apb.pwdata, 32'hDEAD_BEEF);
    step(); // E1: ACCESS cycle 1
    for (int i = 0; i < 4; i++) begin
      check("wr acc penable", {31'd0, apb.penable}, 32'd1);
      check("wr acc psel",    {31'd0, apb.psel}, 32'd1);
      check("wr acc paddr",   {24'd0, apb.paddr}, 32'h08);
      check("wr acc pwdata",  apb.pwdata, 32'hDEAD_BEEF);
      check("wr acc pstrb",   {28'd0, apb.pstrb}, 32'hF);
      check("wr acc rsp_valid", {31'd0, rsp_valid}, 32'd0);
      if (i == 3) apb.pready = 1'b1;
      step();
    end
    check("wr rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr rsp_rdata", rsp_rdata, 32'h0);
    check("wr rsp_err",   {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_idle_outputs("wr retire");
    check("wr held paddr",  {24'd0, apb.paddr}, 32'h08);
    check("wr held pwdata", apb.pwdata, 32'hDEAD_BEEF);
    check("wr held pwrite", {31'd0, apb.pwrite}, 32'd1);

    // Read with pslverr, then backpressure while a second command waits
    send_cmd(1'b0, 8'h0C, 32'h0, 4'h0);
    apb.pready = 1'b1; apb.prdata = 32'h0000_00A5; apb.pslverr = 1'b1;
    step();
    send_cmd(1'b0, 8'h10, 32'h0, 4'h0);
    step();
    step();
    check("err rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("err rsp_err",   {31'd0, rsp_err}, 32'd1);
    check("err rsp_rdata", rsp_rdata, 32'h0000_00A5);
    apb.pslverr = 1'b0; apb.prdata = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp rsp_rdata", rsp_rdata, 32'h0000_00A5);
      check("bp rsp_err",   {31'd0, rsp_err}, 32'd1);
      check("bp cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp psel",      {31'd0, apb.psel}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_idle_outputs("bp retire");
    step();
    cmd_valid = 1'b0;
    check("bp 2nd psel",  {31'd0, apb.psel}, 32'd1);
    check("bp 2nd paddr", {24'd0, apb.paddr}, 32'h10);
    check("bp 2nd cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    step();
    check("bp 2nd rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp 2nd rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
    check("bp 2nd rsp_err",   {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Stalled responder: abort at 16 ACCESS cycles, or indefinite wait
    send_cmd(1'b0, 8'h14, 32'h0, 4'h0);
    apb.pready = 1'b0; apb.prdata = 32'h5A5A_5A5A;
    step();
    cmd_valid = 1'b0;
    step(); // ACCESS cycle 1
`ifdef APB2_INITIATOR_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    check("to cycle16 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("to cycle16 penable",   {31'd0, apb.penable}, 32'd1);
    step();
    check("to rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to rsp_err",   {31'd0, rsp_err}, 32'd1);
    check("to rsp_rdata", rsp_rdata, 32'h0);
    check("to psel",      {31'd0, apb.psel}, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    // pready arrives on ACCESS cycle 16: completion wins
    send_cmd(1'b0, 8'h14, 32'h0, 4'h0);
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    apb.pready = 1'b1; apb.prdata = 32'h00C0_FFEE;
    step();
    check("to win rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to win rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("to win rsp_rdata", rsp_rdata, 32'h00C0_FFEE);
`else
    for (int i = 0; i < 30; i++) begin
      step();
      check("wait rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("wait penable",   {31'd0, apb.penable}, 32'd1);
    end
    apb.pready = 1'b1; apb.prdata = 32'h00C0_FFEE;
    step();
    check("wait rsp_valid done", {31'd0, rsp_valid}, 32'd1);
    check("wait rsp_err",        {31'd0, rsp_err}, 32'd0);
    check("wait rsp_rdata",      rsp_rdata, 32'h00C0_FFEE);
`endif
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset asserted during ACCESS
    send_cmd(1'b1, 8'h18, 32'h1234_5678, 4'h3);
    apb.pready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    check("mid access penable", {31'd0, apb.penable}, 32'd1);
    #2;
    preset_n = 1'b0;
    #1;
    check_idle_outputs("async rst");
    check("async rst paddr",  {24'd0, apb.paddr}, 32'h0);
    check("async rst pwdata", apb.pwdata, 32'h0);
    check("async rst pstrb",  {28'd0, apb.pstrb}, 32'h0);
    check("async rst pwrite", {31'd0, apb.pwrite}, 32'd0);
    check("async rst rsp_rdata", rsp_rdata, 32'h0);
    apb.pready = 1'b1;
    step();
    preset_n = 1'b1;
    step();
    check_idle_outputs("post rst");
    step();
    check("post rst no rsp", {31'd0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/apb2_initiator.md
# apb2_initiator

Single-outstanding APB2 initiator (bus master) for the BLDC controller fabric. It accepts one read or write command at a time on a valid/ready command port, runs the APB SETUP and ACCESS phases against a responder such as the BLDC status peripheral, and returns read data and error status on a valid/ready response port. Soft-core glue and the test harness use it to poll hall state, encoder counter, rotation duration and RPM registers.

## Interface
- data_width, 32, APB data width; a multiple of 8
- addr_width, 8, APB address width
- timeout_cycles, 16, maximum ACCESS wait states before abort; must be ≥1; used only with the timeout feature

Ports:
- pclk  in  1  APB clock; all logic on rising edge
- preset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  initiator can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  addr_width  target address; 4-byte aligned
- cmd_wdata  in  data_width  write data
- cmd_strb  in  data_width/8  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  data_width  read data; 0 for writes and aborts
- rsp_err  out  1  pslverr captured, or timeout abort
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  addr_width; pwdata  out  data_width; pstrb  out  data_width/8; pprot  out  3
- prdata  in  data_width; pready  in  1; pslverr  in  1

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, psel 0, penable 0, pwrite 0, paddr 0, pwdata 0, pstrb 0, pprot 3'b000.
- IDLE: cmd_ready = 1. On an edge with cmd_valid high, latch the command, clear cmd_ready, drive psel = 1, penable = 0, and go to SETUP.
- The latched command drives paddr and pwrite. For writes it also drives pwdata and pstrb. For reads, pwdata = 0 and pstrb = 0.
- pprot is constant 3'b000.
- SETUP: lasts exactly one cycle. On the next edge set penable = 1 and go to ACCESS. pready is ignored in SETUP.
- ACCESS: psel, penable, paddr, pwrite, pwdata and pstrb are held stable. On an edge with pready = 1:
  - rsp_rdata = prdata for reads, 0 for writes.
  - rsp_err = pslverr.
  - psel = penable = 0, rsp_valid = 1, go to RESP.
- pslverr and prdata are sampled only on the completing edge.
- RESP: rsp_valid and the response data are held until an edge with rsp_ready = 1. On that edge rsp_valid = 0, cmd_ready = 1, go to IDLE.
- cmd_ready is 0 outside IDLE. A command cannot be accepted on the same edge that retires a response.
- paddr, pwrite, pwdata and pstrb retain their last values after completion. Only psel and penable return to 0.
- Reset asserted mid-transaction: everything returns to reset values immediately. No response is produced for the dropped command.

## Timing
- Command accepted on edge E0: SETUP visible after E0, ACCESS (penable = 1) visible after E1.
- Zero-wait responder (pready high in the first ACCESS cycle): rsp_valid visible after E2.
- Each ACCESS cycle with pready = 0 adds one cycle.
- With rsp_ready held high, rsp_valid lasts one cycle. The next command can then be accepted at E4 at the earliest, giving a minimum cycle of 4 edges per transaction.
- psel is high for SETUP plus all ACCESS cycles. penable is high for ACCESS cycles only.

## Configuration
- Macro: APB2_INITIATOR_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS edge with pready = 0.
  - On the edge where pready = 0 and the counter equals timeout_cycles − 1, the transfer aborts: psel = penable = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, go to RESP.
  - A pready = 1 on that same edge completes the transfer normally; completion wins.
- Not defined: no counter. ACCESS waits indefinitely for pready.

## Test plan
- Read, zero-wait, addr 0x04, responder returns 0x0000_1234 → psel/penable sequence 10, 11; rsp_valid after E2; rsp_rdata 0x0000_1234, rsp_err 0.
- Write 0xDEAD_BEEF, strb 4'hF, addr 0x08, pready after 3 wait states → paddr, pwdata and pstrb stable across all 4 ACCESS cycles; rsp_valid after E5; rsp_rdata 0.
- Read with pslverr = 1 at completion → rsp_err 1; rsp_rdata holds the sampled prdata.
- rsp_ready held low for 5 cycles while cmd_valid stays high → rsp_valid and data held; cmd_ready 0 throughout; second command accepted only after the response retires.
- Timeout enabled, timeout_cycles = 16, pready tied 0 → abort after 16 ACCESS cycles with rsp_err 1 and rsp_rdata 0. A separate case with pready = 1 on cycle 16 → normal completion.
- preset_n pulsed low during ACCESS → all outputs at reset values asynchronously; no rsp_valid; cmd_ready 1 after release.
